// File: rtl/nco_param_loader.sv
// Parses a 16-bit command stream into 24 shadow NCO words and copies all of
// them to the active outputs in a single cycle on an armed epoch tick.
module nco_param_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        epoch_tick,
  output logic [27:0] fre_carrier0,
  output logic [27:0] fre_carrier1,
  output logic [27:0] fre_carrier2,
  output logic [27:0] fre_carrier3,
  output logic [27:0] fre_carrier4,
  output logic [27:0] fre_carrier5,
  output logic [27:0] fre_carrier6,
  output logic [27:0] fre_carrier7,
  output logic [27:0] fre_1023k0,
  output logic [27:0] fre_1023k1,
  output logic [27:0] fre_1023k2,
  output logic [27:0] fre_1023k3,
  output logic [27:0] fre_1023k4,
  output logic [27:0] fre_1023k5,
  output logic [27:0] fre_1023k6,
  output logic [27:0] fre_1023k7,
  output logic [27:0] pha_1023k0,
  output logic [27:0] pha_1023k1,
  output logic [27:0] pha_1023k2,
  output logic [27:0] pha_1023k3,
  output logic [27:0] pha_1023k4,
  output logic [27:0] pha_1023k5,
  output logic [27:0] pha_1023k6,
  output logic [27:0] pha_1023k7,
  output logic        commit_pulse,
  output logic [7:0]  err_cnt
);

  localparam logic [15:0] SYNC      = 16'hA55A;
  localparam logic [3:0]  OP_WRITE  = 4'h1;
  localparam logic [3:0]  OP_COMMIT = 4'h2;

  typedef enum logic [2:0] {ST_HUNT, ST_HDR, ST_HI, ST_LO, ST_PEND} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [1:0]  sel_q, sel_d;
  logic [11:0] hi_q, hi_d;
  logic        rx_ready_q, rx_ready_d;
  logic        commit_q, commit_d;
  logic [7:0]  err_q, err_d;
  logic        err_evt;
  logic        accept;

  // Indexed [select][channel]: 0 fre_carrier, 1 fre_1023k, 2 pha_1023k.
  logic [27:0] shadow_q [3][8];
  logic [27:0] shadow_d [3][8];
  logic [27:0] active_q [3][8];
  logic [27:0] active_d [3][8];

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    ch_d     = ch_q;
    sel_d    = sel_q;
    hi_d     = hi_q;
    shadow_d = shadow_q;
    active_d = active_q;
    commit_d = 1'b0;
    err_evt  = 1'b0;

    case (state_q)
      ST_HUNT: if (accept && rx_data == SYNC) state_d = ST_HDR;
      ST_HDR: if (accept) begin
        if (rx_data[15:12] == OP_WRITE && rx_data[1:0] != 2'd3) begin
          ch_d    = rx_data[10:8];
          sel_d   = rx_data[1:0];
          state_d = ST_HI;
        end else if (rx_data[15:12] == OP_COMMIT) begin
          state_d = ST_PEND;
        end else begin
          err_evt = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_HI: if (accept) begin
        if (rx_data[15:12] == 4'h0) begin
          hi_d    = rx_data[11:0];
          state_d = ST_LO;
        end else begin
          err_evt = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_LO: if (accept) begin
        shadow_d[sel_q][ch_q] = {hi_q, rx_data};
        state_d               = ST_HUNT;
      end
      ST_PEND: if (epoch_tick) begin
        active_d = shadow_q;
        commit_d = 1'b1;
        state_d  = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase

    err_d      = (err_evt && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    // Registered ready follows the state being entered, so it is already low
    // on the first PEND cycle and high again right after the commit.
    rx_ready_d = (state_d != ST_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      ch_q       <= '0;
      sel_q      <= '0;
      hi_q       <= '0;
      rx_ready_q <= 1'b0;
      commit_q   <= 1'b0;
      err_q      <= '0;
      // NOTE: the register arrays are small flop banks, not RAM, and must
      // read back as zero after reset, so they are cleared here explicitly.
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      sel_q      <= sel_d;
      hi_q       <= hi_d;
      rx_ready_q <= rx_ready_d;
      commit_q   <= commit_d;
      err_q      <= err_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign commit_pulse = commit_q;
  assign err_cnt      = err_q;

  assign fre_carrier0 = active_q[0][0];
  assign fre_carrier1 = active_q[0][1];
  assign fre_carrier2 = active_q[0][2];
  assign fre_carrier3 = active_q[0][3];
  assign fre_carrier4 = active_q[0][4];
  assign fre_carrier5 = active_q[0][5];
  assign fre_carrier6 = active_q[0][6];
  assign fre_carrier7 = active_q[0][7];
  assign fre_1023k0   = active_q[1][0];
  assign fre_1023k1   = active_q[1][1];
  assign fre_1023k2   = active_q[1][2];
  assign fre_1023k3   = active_q[1][3];
  assign fre_1023k4   = active_q[1][4];
  assign fre_1023k5   = active_q[1][5];
  assign fre_1023k6   = active_q[1][6];
  assign fre_1023k7   = active_q[1][7];
  assign pha_1023k0   = active_q[2][0];
  assign pha_1023k1   = active_q[2][1];
  assign pha_1023k2   = active_q[2][2];
  assign pha_1023k3   = active_q[2][3];
  assign pha_1023k4   = active_q[2][4];
  assign pha_1023k5   = active_q[2][5];
  assign pha_1023k6   = active_q[2][6];
  assign pha_1023k7   = active_q[2][7];

endmodule
